byte_encode: RTL and testbench
==============================

BYTE_ENCODE -- requirements
Module: byte_encode

Interface
REQ-001 SHALL have parameter NCOEFF, default 256, number of coefficients per polynomial.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_start  input  1  one-cycle request to begin encoding one polynomial.
REQ-005 SHALL have port i_d  input  4  bits per coefficient; legal values 1, 4, 5, 10, 11, 12; sampled on accepted i_start.
REQ-006 SHALL have port i_coeff  input  12  coefficient; only bits [d-1:0] are used, upper bits ignored.
REQ-007 SHALL have port i_coeff_valid  input  1  i_coeff is valid.
REQ-008 SHALL have port o_coeff_ready  output  1  block accepts i_coeff this cycle.
REQ-009 SHALL have port o_byte  output  8  packed output byte.
REQ-010 SHALL have port o_byte_valid  output  1  o_byte is valid.
REQ-011 SHALL have port i_byte_ready  input  1  downstream accepts o_byte.
REQ-012 SHALL have port o_busy  output  1  high in RUN and DRAIN.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse when the last byte has been transferred.
REQ-014 SHALL have port o_err  output  1  one-cycle pulse when i_start is rejected for an illegal i_d.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: i_start with legal i_d -> RUN; latch d, clear the 19-bit accumulator, bit count (5 bits) and coefficient counter.
REQ-017 IDLE: i_start with illegal i_d -> stay IDLE, pulse o_err the next cycle.
REQ-018 i_start outside IDLE SHALL be ignored (no restart, no o_err).
REQ-019 Coefficient handshake: transfer when o_coeff_ready and i_coeff_valid both high.
REQ-020 o_coeff_ready = (state RUN) and (bit count < 8) and (coefficient counter < NCOEFF).
REQ-021 On coefficient transfer: accumulator |= (i_coeff[d-1:0] << bit count); bit count += d; coefficient counter += 1.
REQ-022 o_byte_valid = (state RUN or DRAIN) and (bit count >= 8); o_byte = accumulator[7:0].
REQ-023 Byte handshake: transfer when o_byte_valid and i_byte_ready both high; accumulator >>= 8; bit count -= 8.
REQ-024 Coefficient and byte transfers SHALL be mutually exclusive per cycle (bit count < 8 vs >= 8).
REQ-025 Packing SHALL be LSB-first: coefficient 0 bit 0 is o_byte bit 0 of the first byte.
REQ-026 Latency: a byte completed by a coefficient transfer SHALL be valid on o_byte the following cycle.
REQ-027 o_byte and o_byte_valid SHALL hold stable while o_byte_valid is high and i_byte_ready is low.
REQ-028 RUN -> DRAIN when the coefficient counter reaches NCOEFF.
REQ-029 DRAIN -> DONE when bit count reaches 0 after a byte transfer; exactly 32*d bytes are emitted per NCOEFF=256.
REQ-030 DONE: assert o_done for one cycle, then return to IDLE.
REQ-031 Throughput: with no backpressure and continuous valid input, no idle cycles beyond the exclusivity of REQ-024.

Reset
REQ-032 While i_rstn is low: state IDLE; accumulator, bit count, coefficient counter and latched d cleared; o_coeff_ready, o_byte_valid, o_busy, o_done, o_err all 0; o_byte 0.
REQ-033 Reset asserted mid-operation SHALL abort immediately with no further bytes emitted; the next i_start begins a fresh polynomial.

Verification
REQ-034 d=1, 256 coefficients all 0xFFF -> exactly 32 bytes of 0xFF, then one o_done pulse.
REQ-035 d=12, coefficients 0xABC, 0x123, rest 0 -> first three bytes 0xBC, 0x3A, 0x12; 384 bytes total.
REQ-036 d=4, coefficients 0x1, 0x2 repeated -> every byte 0x21; 128 bytes; random i_byte_ready backpressure yields an identical byte sequence with o_byte stable while stalled.
REQ-037 i_start with i_d=7 -> o_err pulse, o_busy stays 0; a following i_start with i_d=5 then encodes normally (160 bytes).
REQ-038 Reset asserted after 100 coefficients with d=10 -> all outputs 0 next cycle; a restarted run emits 320 bytes matching the golden model.
REQ-039 i_start pulsed during RUN -> ignored; byte count and contents unchanged versus a run without it.

Source files
------------

// File: rtl/byte_encode_if.sv
// byte_encode_if: bundles the control, coefficient-input and byte-output handshakes of
// byte_encode.
//   i_start / i_d                  : request to encode one polynomial at d bits per coefficient
//   i_coeff / i_coeff_valid / o_coeff_ready : coefficient stream into the packer
//   o_byte / o_byte_valid / i_byte_ready    : packed byte stream out of the packer
//   o_busy / o_done / o_err        : status (running, last byte sent, start rejected)
// master: the side that feeds coefficients and consumes bytes. slave: the encoder.
interface byte_encode_if;
    logic        i_start;
    logic [3:0]  i_d;
    logic [11:0] i_coeff;
    logic        i_coeff_valid;
    logic        o_coeff_ready;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        i_byte_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_start, i_d, i_coeff, i_coeff_valid, i_byte_ready,
        input  o_coeff_ready, o_byte, o_byte_valid, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_d, i_coeff, i_coeff_valid, i_byte_ready,
        output o_coeff_ready, o_byte, o_byte_valid, o_busy, o_done, o_err
    );
endinterface

// File: rtl/byte_encode.sv
// byte_encode: packs NCOEFF coefficients of d bits each (d in {1,4,5,10,11,12}) into an
// LSB-first byte stream.
// Ports:
//   i_clk  : clock, all state on the rising edge
//   i_rstn : asynchronous active-low reset
//   bus    : byte_encode_if.slave (start/d, coefficient stream, byte stream, status)
// A 19-bit accumulator holds the not-yet-emitted bits. Coefficients are accepted only while
// fewer than 8 bits are pending, and bytes are offered only while 8 or more are pending, so
// the two handshakes never fire in the same cycle.
module byte_encode #(
    parameter int unsigned NCOEFF = 256
) (
    input logic          i_clk,
    input logic          i_rstn,
    byte_encode_if.slave bus
);
    localparam int unsigned CntW = $clog2(NCOEFF + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [18:0]     acc_q, acc_d;
    logic [4:0]      bcnt_q, bcnt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      d_q, d_d;
    logic            err_q, err_d;

    logic        coeff_ready;
    logic        byte_valid;
    logic        coeff_fire;
    logic        byte_fire;
    logic [11:0] mask;
    logic [18:0] coeff_bits;

    function automatic logic d_legal(input logic [3:0] d);
        case (d)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: d_legal = 1'b1;
            default:                               d_legal = 1'b0;
        endcase
    endfunction

    assign coeff_ready = (state_q == StRun) && (bcnt_q < 5'd8) && (cnt_q < CntW'(NCOEFF));
    assign byte_valid  = ((state_q == StRun) || (state_q == StDrain)) && (bcnt_q >= 5'd8);
    assign coeff_fire  = coeff_ready && bus.i_coeff_valid;
    assign byte_fire   = byte_valid && bus.i_byte_ready;

    // d_q never exceeds 12, so the 13-bit shift cannot overflow.
    assign mask       = 12'((13'd1 << d_q) - 13'd1);
    assign coeff_bits = {7'd0, bus.i_coeff & mask};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        err_d   = 1'b0;

        // Packing datapath; only active in RUN/DRAIN through the ready/valid terms.
        if (coeff_fire) begin
            // bcnt_q < 8 here, so the shifted coefficient fits in 19 bits.
            acc_d  = acc_q | (coeff_bits << bcnt_q);
            bcnt_d = bcnt_q + {1'b0, d_q};
            cnt_d  = cnt_q + 1'b1;
        end else if (byte_fire) begin
            acc_d  = acc_q >> 8;
            bcnt_d = bcnt_q - 5'd8;
        end

        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    if (d_legal(bus.i_d)) begin
                        state_d = StRun;
                        d_d     = bus.i_d;
                        acc_d   = '0;
                        bcnt_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (cnt_d == CntW'(NCOEFF)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Second term guards against entering DRAIN with nothing pending.
                if ((byte_fire && (bcnt_d == 5'd0)) || (bcnt_q == 5'd0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_coeff_ready = coeff_ready;
    assign bus.o_byte_valid  = byte_valid;
    assign bus.o_byte        = acc_q[7:0];
    assign bus.o_busy        = (state_q == StRun) || (state_q == StDrain);
    assign bus.o_done        = (state_q == StDone);
    assign bus.o_err         = err_q;
endmodule

// File: tb/tb_byte_encode.sv
// Self-checking bench for byte_encode: expected bytes are queued when a polynomial is set up,
// and an independent monitor pops and compares every byte the encoder hands over.
module tb_byte_encode;
    logic clk;
    logic rstn;

    byte_encode_if bus ();

    byte_encode #(.NCOEFF(256)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          passes;
    int          done_cnt;
    int          err_cnt;
    int          rx_cnt;
    logic        bp_en;
    logic [7:0]  exp_q[$];
    logic [11:0] coeffs[256];
    logic        prev_stall;
    logic [7:0]  prev_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Bitstream reference: append d bits of each coefficient LSB-first, cut every 8 bits.
    task automatic push_model(input int d, input int n);
        logic [7:0] b;
        int nb;
        b = '0;
        nb = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < d; k++) begin
                b[nb] = coeffs[i][k];
                nb++;
                if (nb == 8) begin
                    exp_q.push_back(b);
                    b = '0;
                    nb = 0;
                end
            end
        end
    endtask

    // Monitor: byte scoreboard, stall stability, status pulse counters.
    initial begin
        prev_stall = 1'b0;
        prev_byte  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_hold", 32'(bus.o_byte_valid), 32'd1);
                    check("stall_byte_hold", 32'(bus.o_byte), 32'(prev_byte));
                end
                if (bus.o_done) done_cnt++;
                if (bus.o_err) err_cnt++;
                if (bus.o_byte_valid && bus.i_byte_ready) begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus.o_byte);
                    end else begin
                        check("byte", 32'(bus.o_byte), 32'(exp_q.pop_front()));
                    end
                end
                prev_stall = bus.o_byte_valid && !bus.i_byte_ready;
                prev_byte  = bus.o_byte;
            end
        end
    end

    // Downstream ready, optionally randomised.
    initial begin
        bus.i_byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.i_byte_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start(input logic [3:0] d);
        @(posedge clk);
        #1;
        bus.i_start = 1'b1;
        bus.i_d     = d;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic feed(input int n);
        int   i;
        int   guard;
        logic hs;
        i = 0;
        guard = 0;
        bus.i_coeff       = coeffs[0];
        bus.i_coeff_valid = 1'b1;
        while (i < n) begin
            @(negedge clk);
            hs = bus.o_coeff_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                i++;
                if (i < n) bus.i_coeff = coeffs[i];
            end
            guard++;
            if (guard > 5000) begin
                check("feed_timeout", 32'(i), 32'(n));
                break;
            end
        end
        bus.i_coeff_valid = 1'b0;
    endtask

    task automatic finish_run(input string name, input int exp_len, input int done_before);
        int k;
        k = 0;
        while (done_cnt == done_before && k < 5000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({name, "_done_pulses"}, 32'(done_cnt), 32'(done_before + 1));
        check({name, "_byte_count"}, 32'(rx_cnt), 32'(exp_len));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_after"}, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_coeff_ready"}, 32'(bus.o_coeff_ready), 32'd0);
        check({name, "_byte_valid"}, 32'(bus.o_byte_valid), 32'd0);
        check({name, "_byte"}, 32'(bus.o_byte), 32'd0);
        check({name, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({name, "_done"}, 32'(bus.o_done), 32'd0);
        check({name, "_err"}, 32'(bus.o_err), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        checks = 0;
        passes = 0;
        done_cnt = 0;
        err_cnt = 0;
        rx_cnt = 0;
        bp_en = 1'b0;
        rstn = 1'b0;
        bus.i_start = 1'b0;
        bus.i_d = '0;
        bus.i_coeff = '0;
        bus.i_coeff_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // d=1, all ones: 32 bytes of 0xFF.
        for (int i = 0; i < 256; i++) coeffs[i] = 12'hFFF;
        for (int i = 0; i < 32; i++) exp_q.push_back(8'hFF);
        rx_cnt = 0;
        d0 = done_cnt;
        start(4'd1);
        feed(256);
        finish_run("d1_ones", 32, d0);

        // d=12: 0xABC, 0x123, zeros -> BC 3A 12 then 381 zero bytes.
        for (int i = 0; i < 256; i++) coeffs[i] = 12'h000;
        coeffs[0] = 12'hABC;
        coeffs[1] = 12'h123;
        exp_q.push_back(8'hBC);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'h12);
        for (int i = 3; i < 384; i++) exp_q.push_back(8'h00);
        rx_cnt = 0;
        d0 = done_cnt;
        start(4'd12);
        feed(256);
        finish_run("d12", 384, d0);

        // d=4, 1,2 repeated with random backpressure: every byte 0x21.
        for (int i = 0; i < 256; i++) coeffs[i] = (i % 2 == 0) ? 12'hF01 : 12'h7E2;
        for (int i = 0; i < 128; i++) exp_q.push_back(8'h21);
        bp_en = 1'b1;
        rx_cnt = 0;
        d0 = done_cnt;
        start(4'd4);
        feed(256);
        finish_run("d4_bp", 128, d0);
        bp_en = 1'b0;

        // Illegal d=7: one o_err pulse, never busy; then d=5 encodes normally.
        e0 = err_cnt;
        start(4'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("illegal_busy", 32'(bus.o_busy), 32'd0);
        end
        check("illegal_err_pulses", 32'(err_cnt), 32'(e0 + 1));
        for (int i = 0; i < 256; i++) coeffs[i] = 12'(i * 7 + 3);
        push_model(5, 256);
        rx_cnt = 0;
        d0 = done_cnt;
        start(4'd5);
        feed(256);
        finish_run("d5_after_err", 160, d0);
        check("d5_no_err", 32'(err_cnt), 32'(e0 + 1));

        // d=10: reset after 100 coefficients aborts; a restarted run matches the model.
        for (int i = 0; i < 256; i++) coeffs[i] = 12'(i * 37 + 12'hC00);
        push_model(10, 256);
        start(4'd10);
        feed(100);
        rstn = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrun_reset");
        @(negedge clk);
        check("midrun_reset_no_byte", 32'(bus.o_byte_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        push_model(10, 256);
        rx_cnt = 0;
        d0 = done_cnt;
        start(4'd10);
        feed(256);
        finish_run("d10_restart", 320, d0);

        // d=11 with a stray i_start (d=4) mid-run: stream unchanged.
        for (int i = 0; i < 256; i++) coeffs[i] = 12'(i * 91) ^ 12'h5A5;
        push_model(11, 256);
        rx_cnt = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        start(4'd11);
        fork
            feed(256);
            begin
                repeat (40) @(posedge clk);
                #1;
                bus.i_start = 1'b1;
                bus.i_d = 4'd4;
                @(posedge clk);
                #1;
                bus.i_start = 1'b0;
            end
        join
        finish_run("d11_stray_start", 352, d0);
        check("d11_no_err", 32'(err_cnt), 32'(e0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
